// File: rtl/pico_axi_wdata_scheduler.sv
// pico_axi_wdata_scheduler: order FIFO of AW grants steering the shared W channel one whole burst at a time.
// Optional feature PICO_WSCHED_LEN_CHECK_EN: burst end taken from the stored AWLEN, with a sticky WLAST mismatch flag.
module pico_axi_wdata_scheduler #(
   parameter int C_NUM_SLAVE_PORTS     = 4,
   parameter int LOG_C_NUM_SLAVE_PORTS = 2,
   parameter int ORDER_DEPTH           = 8,
   parameter int LOG_ORDER_DEPTH       = 3
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             aw_push,
   input  logic [LOG_C_NUM_SLAVE_PORTS-1:0] aw_slave,
   input  logic [7:0]                       aw_len,
   output logic                             order_full,
   output logic [LOG_ORDER_DEPTH:0]         order_count,
   input  logic [C_NUM_SLAVE_PORTS-1:0]     s_axi_wvalid,
   input  logic [C_NUM_SLAVE_PORTS-1:0]     s_axi_wlast,
   output logic [C_NUM_SLAVE_PORTS-1:0]     s_axi_wready,
   output logic [LOG_C_NUM_SLAVE_PORTS-1:0] wSel,
   output logic                             m_axi_wvalid,
   output logic                             m_axi_wlast,
   input  logic                             m_axi_wready,
   output logic                             len_err
);

   typedef enum logic {ST_IDLE, ST_ACTIVE} state_e;

`ifdef PICO_WSCHED_LEN_CHECK_EN
   localparam int ENTRY_W = LOG_C_NUM_SLAVE_PORTS + 8;
`else
   localparam int ENTRY_W = LOG_C_NUM_SLAVE_PORTS;
`endif
   localparam logic [LOG_ORDER_DEPTH:0] FULL_COUNT = (LOG_ORDER_DEPTH+1)'(ORDER_DEPTH);
   localparam logic [LOG_ORDER_DEPTH:0] TWO_COUNT  = (LOG_ORDER_DEPTH+1)'(2);

   logic [ENTRY_W-1:0]               mem_q [ORDER_DEPTH];
   logic [LOG_ORDER_DEPTH-1:0]       wr_ptr_q, rd_ptr_q, rd_next;
   logic [LOG_ORDER_DEPTH:0]         count_q, count_d;
   state_e                           state_q, state_d;
   logic [LOG_C_NUM_SLAVE_PORTS-1:0] wsel_q, wsel_d;
   logic [ENTRY_W-1:0]               wr_entry, load_entry;
   logic                             push, pop, active, beat, final_beat, sel_last, load;

   assign rd_next      = rd_ptr_q + 1'b1;
   assign active       = (state_q == ST_ACTIVE);
   assign sel_last     = s_axi_wlast[wsel_q];
   assign m_axi_wvalid = active & s_axi_wvalid[wsel_q];
   assign beat         = m_axi_wvalid & m_axi_wready;
   assign order_full   = (count_q == FULL_COUNT);
   assign push         = aw_push & ~order_full;
   assign pop          = final_beat;
   assign order_count  = count_q;
   assign wSel         = wsel_q;

`ifdef PICO_WSCHED_LEN_CHECK_EN
   logic [7:0] beat_cnt_q, beat_cnt_d;
   logic       cnt_zero, len_err_q, len_err_d;

   assign wr_entry    = {aw_slave, aw_len};
   assign cnt_zero    = (beat_cnt_q == 8'd0);
   assign final_beat  = beat & cnt_zero;
   assign m_axi_wlast = active & cnt_zero;
   assign len_err     = len_err_q;

   always_comb begin
      beat_cnt_d = beat_cnt_q;
      if (load)
         beat_cnt_d = load_entry[7:0];
      else if (beat && !cnt_zero)
         beat_cnt_d = beat_cnt_q - 8'd1;
      len_err_d = len_err_q | (beat & (sel_last != cnt_zero));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt_q <= 8'd0;
         len_err_q  <= 1'b0;
      end else begin
         beat_cnt_q <= beat_cnt_d;
         len_err_q  <= len_err_d;
      end
   end
`else
   logic unused_len;

   assign wr_entry    = aw_slave;
   assign final_beat  = beat & sel_last;
   assign m_axi_wlast = active & sel_last;
   assign len_err     = 1'b0;
   assign unused_len  = ^aw_len;
`endif

   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      s_axi_wready         = '0;
      s_axi_wready[wsel_q] = active & m_axi_wready;
   end

   // A final beat with another grant already queued reloads from the entry behind the head: no bubble.
   always_comb begin
      state_d    = state_q;
      wsel_d     = wsel_q;
      load       = 1'b0;
      load_entry = mem_q[rd_ptr_q];
      case (state_q)
         ST_IDLE: begin
            if (count_q != '0) begin
               load    = 1'b1;
               state_d = ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            if (final_beat) begin
               if (count_q >= TWO_COUNT) begin
                  load       = 1'b1;
                  load_entry = mem_q[rd_next];
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (load)
         wsel_d = load_entry[ENTRY_W-1 -: LOG_C_NUM_SLAVE_PORTS];
   end

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // NOTE: sequential state is written with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         wsel_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q <= state_d;
         wsel_q  <= wsel_d;
         count_q <= count_d;
         if (push)
            wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)
            rd_ptr_q <= rd_next;
      end
   end

   // NOTE: the entry storage is not reset; the pointers and count alone decide which entries are valid.
   always_ff @(posedge clk) begin
      if (push)
         mem_q[wr_ptr_q] <= wr_entry;
   end

endmodule

// File: tb/tb_pico_axi_wdata_scheduler.sv
// Self-checking bench for pico_axi_wdata_scheduler: slave-side burst model plus a beat scoreboard.
// Build with PICO_WSCHED_LEN_CHECK_EN defined to also exercise the length-check feature.
module tb_pico_axi_wdata_scheduler;

   localparam int NS  = 4;
   localparam int LNS = 2;
   localparam int LD  = 3;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           aw_push;
   logic [LNS-1:0] aw_slave;
   logic [7:0]     aw_len;
   logic           order_full;
   logic [LD:0]    order_count;
   logic [NS-1:0]  s_axi_wvalid, s_axi_wlast, s_axi_wready;
   logic [LNS-1:0] wSel;
   logic           m_axi_wvalid, m_axi_wlast, m_axi_wready;
   logic           len_err;

   pico_axi_wdata_scheduler dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .aw_push      (aw_push),
      .aw_slave     (aw_slave),
      .aw_len       (aw_len),
      .order_full   (order_full),
      .order_count  (order_count),
      .s_axi_wvalid (s_axi_wvalid),
      .s_axi_wlast  (s_axi_wlast),
      .s_axi_wready (s_axi_wready),
      .wSel         (wSel),
      .m_axi_wvalid (m_axi_wvalid),
      .m_axi_wlast  (m_axi_wlast),
      .m_axi_wready (m_axi_wready),
      .len_err      (len_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [LNS-1:0] slave;
      logic           last;
   } beat_t;

   beat_t         exp_q[$];
   int unsigned   sl_len[NS][$];
   int            sl_bcnt[NS];
   int            beat_cyc_q[$];
   bit            slaves_en;
   logic [NS-1:0] extra_valid;
   logic [NS-1:0] acc_mask;
   int            force_last;
   int            n_checks, n_fail, beats_seen, cyc;

   task automatic drive_slaves();
      for (int i = 0; i < NS; i++) begin
         s_axi_wvalid[i] = extra_valid[i];
         s_axi_wlast[i]  = 1'b0;
         if (slaves_en && sl_len[i].size() != 0) begin
            s_axi_wvalid[i] = 1'b1;
            if (force_last >= 0)
               s_axi_wlast[i] = (sl_bcnt[i] == force_last);
            else
               s_axi_wlast[i] = (sl_bcnt[i] == int'(sl_len[i][0]));
         end
      end
   endtask

   // One clock: compare any beat at the falling edge, then update the slave model just after the rising edge.
   task automatic tick();
      beat_t e;
      @(negedge clk);
      acc_mask = s_axi_wready & s_axi_wvalid;
      if (m_axi_wvalid && m_axi_wready) begin
         n_checks++;
         beats_seen++;
         beat_cyc_q.push_back(cyc);
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_beat: wSel=%0d accepted=%b, scoreboard empty", wSel, acc_mask);
         end else begin
            e = exp_q.pop_front();
            if (acc_mask !== (NS'(1) << e.slave) || m_axi_wlast !== e.last) begin
               n_fail++;
               $display("FAIL beat_order: accepted=%b wlast=%b, expected accepted=%b wlast=%b",
                        acc_mask, m_axi_wlast, NS'(1) << e.slave, e.last);
            end
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < NS; i++) begin
         if (acc_mask[i] && sl_len[i].size() != 0) begin
            if (sl_bcnt[i] == int'(sl_len[i][0])) begin
               void'(sl_len[i].pop_front());
               sl_bcnt[i] = 0;
            end else begin
               sl_bcnt[i]++;
            end
         end
      end
      drive_slaves();
   endtask

   task automatic push_aw(input int s, input int len, input bit accepted);
      aw_push  = 1'b1;
      aw_slave = s[LNS-1:0];
      aw_len   = len[7:0];
      if (accepted) begin
         for (int k = 0; k <= len; k++)
            exp_q.push_back('{slave: s[LNS-1:0], last: (k == len)});
         sl_len[s].push_back(len);
         drive_slaves();
      end
      tick();
      aw_push = 1'b0;
   endtask

   task automatic drain(input string name, input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_timeout: %0d beats still pending, expected 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic wait_beats(input string name, input int target, input int budget);
      int n = 0;
      while (beats_seen < target && n < budget) begin
         tick();
         n++;
      end
      n_checks++;
      if (beats_seen < target) begin
         n_fail++;
         $display("FAIL %s_timeout: beats=%0d, expected %0d", name, beats_seen, target);
      end
   endtask

   task automatic test_reset();
      #2;
      n_checks++;
      if ({order_full, order_count, wSel, s_axi_wready, m_axi_wvalid, m_axi_wlast, len_err} !== '0) begin
         n_fail++;
         $display("FAIL reset_values: full=%b count=%0d wSel=%0d wready=%b wvalid=%b wlast=%b len_err=%b, expected all 0",
                  order_full, order_count, wSel, s_axi_wready, m_axi_wvalid, m_axi_wlast, len_err);
      end
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      push_aw(2, 3, 1'b1);
      n_checks++;
      if (order_count !== 4'd1 || m_axi_wvalid !== 1'b0 || s_axi_wready !== 4'b0000) begin
         n_fail++;
         $display("FAIL single_idle: count=%0d wvalid=%b wready=%b, expected 1 0 0000", order_count, m_axi_wvalid, s_axi_wready);
      end
      tick();
      n_checks++;
      if (wSel !== 2'd2 || m_axi_wvalid !== 1'b1 || s_axi_wready !== 4'b0100) begin
         n_fail++;
         $display("FAIL single_active: wSel=%0d wvalid=%b wready=%b, expected 2 1 0100", wSel, m_axi_wvalid, s_axi_wready);
      end
      drain("single", 20);
      n_checks++;
      if (order_count !== 4'd0 || m_axi_wvalid !== 1'b0 || s_axi_wready !== 4'b0000) begin
         n_fail++;
         $display("FAIL single_return_idle: count=%0d wvalid=%b wready=%b, expected 0 0 0000", order_count, m_axi_wvalid, s_axi_wready);
      end
   endtask

   task automatic test_back_to_back();
      beat_cyc_q.delete();
      push_aw(1, 0, 1'b1);
      push_aw(3, 1, 1'b1);
      push_aw(0, 0, 1'b1);
      drain("b2b", 30);
      n_checks++;
      if (beat_cyc_q.size() != 4) begin
         n_fail++;
         $display("FAIL b2b_beat_count: beats=%0d, expected 4", beat_cyc_q.size());
      end else if (beat_cyc_q[3] - beat_cyc_q[0] != 3) begin
         n_fail++;
         $display("FAIL b2b_no_bubble: span=%0d cycles, expected 3", beat_cyc_q[3] - beat_cyc_q[0]);
      end
   endtask

   task automatic test_full();
      slaves_en = 1'b0;
      drive_slaves();
      for (int i = 0; i < 8; i++) begin
         push_aw(i % NS, 0, 1'b1);
         if (i == 6) begin
            n_checks++;
            if (order_count !== 4'd7 || order_full !== 1'b0) begin
               n_fail++;
               $display("FAIL full_almost: count=%0d full=%b, expected 7 0", order_count, order_full);
            end
         end
      end
      n_checks++;
      if (order_count !== 4'd8 || order_full !== 1'b1) begin
         n_fail++;
         $display("FAIL full_flag: count=%0d full=%b, expected 8 1", order_count, order_full);
      end
      push_aw(3, 5, 1'b0);
      n_checks++;
      if (order_count !== 4'd8 || order_full !== 1'b1) begin
         n_fail++;
         $display("FAIL full_drop: count=%0d full=%b, expected 8 1", order_count, order_full);
      end
      slaves_en = 1'b1;
      drive_slaves();
      drain("full", 40);
      repeat (3) tick();
      n_checks++;
      if (order_count !== 4'd0 || order_full !== 1'b0) begin
         n_fail++;
         $display("FAIL full_drained: count=%0d full=%b, expected 0 0", order_count, order_full);
      end
   endtask

   task automatic test_mux_isolation();
      slaves_en   = 1'b0;
      extra_valid = 4'b0010;
      drive_slaves();
      push_aw(0, 1, 1'b1);
      tick();
      n_checks++;
      if (wSel !== 2'd0 || m_axi_wvalid !== 1'b0 || s_axi_wready !== 4'b0001) begin
         n_fail++;
         $display("FAIL mux_stalled: wSel=%0d wvalid=%b wready=%b, expected 0 0 0001", wSel, m_axi_wvalid, s_axi_wready);
      end
      slaves_en = 1'b1;
      drive_slaves();
      #1;
      n_checks++;
      if (m_axi_wvalid !== 1'b1 || s_axi_wready !== 4'b0001) begin
         n_fail++;
         $display("FAIL mux_follow: wvalid=%b wready=%b, expected 1 0001", m_axi_wvalid, s_axi_wready);
      end
      drain("mux", 20);
      extra_valid = 4'b0000;
      drive_slaves();
   endtask

   task automatic test_reset_mid_burst();
      int b;
      b = beats_seen;
      push_aw(3, 3, 1'b1);
      wait_beats("rst_mid", b + 2, 20);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({order_full, order_count, wSel, s_axi_wready, m_axi_wvalid, m_axi_wlast, len_err} !== '0) begin
         n_fail++;
         $display("FAIL rst_mid_values: full=%b count=%0d wSel=%0d wready=%b wvalid=%b wlast=%b len_err=%b, expected all 0",
                  order_full, order_count, wSel, s_axi_wready, m_axi_wvalid, m_axi_wlast, len_err);
      end
      exp_q.delete();
      sl_len[3].delete();
      sl_bcnt[3]  = 0;
      extra_valid = 4'b1000;
      drive_slaves();
      repeat (2) tick();
      rst_n = 1'b1;
      b = beats_seen;
      repeat (6) tick();
      n_checks++;
      if (beats_seen != b || order_count !== 4'd0 || m_axi_wvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid_flushed: new_beats=%0d count=%0d wvalid=%b, expected 0 0 0",
                  beats_seen - b, order_count, m_axi_wvalid);
      end
      extra_valid = 4'b0000;
      drive_slaves();
   endtask

`ifdef PICO_WSCHED_LEN_CHECK_EN
   task automatic test_len_check();
      int b;
      b = beats_seen;
      force_last = 1;
      push_aw(2, 3, 1'b1);
      wait_beats("len_b1", b + 1, 20);
      n_checks++;
      if (len_err !== 1'b0) begin
         n_fail++;
         $display("FAIL len_err_early: len_err=%b, expected 0", len_err);
      end
      wait_beats("len_b2", b + 2, 20);
      n_checks++;
      if (len_err !== 1'b1) begin
         n_fail++;
         $display("FAIL len_err_set: len_err=%b, expected 1", len_err);
      end
      drain("len", 20);
      force_last = -1;
      drive_slaves();
      repeat (4) tick();
      n_checks++;
      if (len_err !== 1'b1) begin
         n_fail++;
         $display("FAIL len_err_sticky: len_err=%b, expected 1", len_err);
      end
   endtask
`else
   task automatic test_len_check();
      n_checks++;
      if (len_err !== 1'b0) begin
         n_fail++;
         $display("FAIL len_err_tied: len_err=%b, expected 0", len_err);
      end
   endtask
`endif

   initial begin
      aw_push      = 1'b0;
      aw_slave     = '0;
      aw_len       = '0;
      m_axi_wready = 1'b1;
      slaves_en    = 1'b1;
      extra_valid  = '0;
      force_last   = -1;
      n_checks     = 0;
      n_fail       = 0;
      beats_seen   = 0;
      cyc          = 0;
      for (int i = 0; i < NS; i++) sl_bcnt[i] = 0;
      drive_slaves();
      test_reset();
      test_single();
      test_back_to_back();
      test_full();
      test_mux_isolation();
      test_reset_mid_burst();
      test_len_check();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
